sin_scheduler: RTL and testbench
================================

// Module: sin_scheduler
// PURPOSE
//  Shares one CORDIC sin/cos engine between NREQ requesters, e.g. phase A/B/C of the actuator drive.
//  Grants are round-robin. Operands are held stable for the whole engine transaction. The engine's
//  enable/finish handshake is sequenced here, and results are returned with a per-requester ack pulse.
//  A watchdog recovers a hung engine by pulsing its active-low reset.
// PARAMETERS
//  WIDTH   16  operand/result width (engine angle/amplitude/cos/sin)
//  NREQ    3   number of requesters (2..8)
//  TIMEOUT 63  max cycles in ISSUE+WAIT before abort (>= 32)
// PORTS
//  clk_i            in   1           clock
//  reset_i          in   1           asynchronous, active-high reset
//  req_i            in   NREQ        level request; requester k holds req_i[k] and its operands until ack_o[k]
//  amplitude_i      in   NREQ*WIDTH  operands, slice k = [k*WIDTH +: WIDTH]
//  angle_i          in   NREQ*WIDTH  operands, slice k = [k*WIDTH +: WIDTH]
//  ack_o            out  NREQ        one-cycle completion pulse to the granted requester
//  err_o            out  1           high with ack_o when the transaction timed out
//  cos_o, sin_o     out  WIDTH       result of the last successful transaction; held between acks
//  grant_o          out  3           index of the requester in service (valid while busy_o)
//  busy_o           out  1           high in every state except IDLE
//  eng_enable_o     out  1           to engine enable_i
//  eng_amplitude_o  out  WIDTH       to engine amplitude_i
//  eng_angle_o      out  WIDTH       to engine angle_i
//  eng_nreset_o     out  1           to engine nReset_i (active-low, synchronous in the engine)
//  eng_finish_i     in   1           from engine finish_o
//  eng_cos_i        in   WIDTH       from engine cos_o
//  eng_sin_i        in   WIDTH       from engine sin_o
// BEHAVIOUR
//  All outputs are registered. Reset state:
//   - ack/err/busy/eng_enable = 0; cos/sin/eng_amp/eng_angle = 0; grant = 0
//   - eng_nreset_o = 0, and it goes to 1 on the first clock after reset_i falls
//   - round-robin pointer = NREQ-1, so requester 0 wins first
//  FSM states: IDLE, ISSUE, WAIT, DONE, RECOVER.
//  IDLE
//   - If any req_i is set, grant the first requesting index after the pointer, with wrap-around.
//   - Latch that requester's amplitude/angle into eng_amplitude_o/eng_angle_o; set grant_o.
//   - eng_enable_o <= 1; clear the watchdog; go to ISSUE.
//   - A requester's operands are sampled only in its grant cycle; later changes are ignored.
//  ISSUE
//   - Hold eng_enable_o = 1 until eng_finish_i is sampled 0 (engine accepted).
//   - Then eng_enable_o <= 0 and go to WAIT.
//  WAIT
//   - On eng_finish_i = 1: cos_o/sin_o <= eng_cos_i/eng_sin_i; go to DONE.
//  DONE (exactly 1 cycle)
//   - ack_o[grant] = 1, err_o = 0; pointer <= grant; go to IDLE.
//   - The requester drops req on the clock after ack, so it is never re-granted spuriously.
//  Watchdog
//   - Counts every cycle spent in ISSUE or WAIT.
//   - On reaching TIMEOUT: eng_enable_o <= 0, eng_nreset_o <= 0, go to RECOVER.
//  RECOVER (2 cycles, eng_nreset_o = 0)
//   - Last cycle: ack_o[grant] = 1, err_o = 1, cos_o/sin_o unchanged, pointer <= grant.
//   - Then eng_nreset_o <= 1 and go to IDLE.
//  Engine latency between accept and finish is not assumed; only the handshake is used.
//  A request dropped before grant is lost with no ack. A request dropped after grant still
//   completes and acks.
//  A requester that re-asserts req in IDLE is arbitrated fresh; a single requester gets
//   back-to-back service with 1 IDLE cycle between transactions.
//  reset_i mid-transaction: the FSM aborts immediately, no ack is issued, and the engine is reset.
//  Per-transaction overhead beyond engine latency: 3 cycles (IDLE grant, ISSUE accept, DONE).
// TESTING
//  Bench uses a stub engine: finish drops the cycle after enable && finish, returns L cycles later
//  with cos = angle, sin = amplitude.
//  1. Single request, L=20: req[1] with amp=16'h1000, ang=16'h2000 -> ack_o=3'b010 once, err=0,
//     cos_o=16'h2000, sin_o=16'h1000, at 3+L cycles after grant.
//  2. All three requesting from reset, different operands -> acks in order 0,1,2 with matching
//     results; repeat with all held -> order 0,1,2 again.
//  3. After serving 1, requesters 0 and 2 pending -> 2 is granted before 0 (wrap-around).
//  4. Stub hangs (finish stays 0): req[0] -> ack_o[0]=1 with err_o=1 at TIMEOUT+2 cycles;
//     eng_nreset_o low for 2 cycles; cos/sin unchanged; the next request then succeeds.
//  5. Operands change and req drops one cycle after grant -> engine still sees the latched values
//     and ack is delivered.
//  6. reset_i pulsed during WAIT -> all outputs at reset values, no ack, eng_nreset_o low;
//     a fresh request after release completes normally.

Source files
------------

// File: rtl/sin_scheduler.sv
// Round-robin arbiter that shares one CORDIC sin/cos engine between NREQ requesters,
// sequencing the engine enable/finish handshake and recovering a hung engine via its reset.
module sin_scheduler #(
  parameter int WIDTH   = 16,
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 63
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] amplitude_i,
  input  logic [NREQ*WIDTH-1:0] angle_i,
  output logic [NREQ-1:0]       ack_o,
  output logic                  err_o,
  output logic [WIDTH-1:0]      cos_o,
  output logic [WIDTH-1:0]      sin_o,
  output logic [2:0]            grant_o,
  output logic                  busy_o,
  output logic                  eng_enable_o,
  output logic [WIDTH-1:0]      eng_amplitude_o,
  output logic [WIDTH-1:0]      eng_angle_o,
  output logic                  eng_nreset_o,
  input  logic                  eng_finish_i,
  input  logic [WIDTH-1:0]      eng_cos_i,
  input  logic [WIDTH-1:0]      eng_sin_i
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [2:0]      PTR_RST = 3'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_RECOVER
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        grant_q, grant_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              rec_q, rec_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  cos_q, cos_d;
  logic [WIDTH-1:0]  sin_q, sin_d;
  logic              busy_q, busy_d;
  logic              en_q, en_d;
  logic [WIDTH-1:0]  amp_q, amp_d;
  logic [WIDTH-1:0]  ang_q, ang_d;
  logic              nrst_q, nrst_d;

  logic [3:0]            pick;
  logic [NREQ*WIDTH-1:0] amp_sh;
  logic [NREQ*WIDTH-1:0] ang_sh;
  logic [NREQ-1:0]       ack_onehot;

  // Nearest requester after ptr (with wrap) wins; scanning farthest-first lets it overwrite.
  function automatic logic [3:0] rr_pick(input logic [NREQ-1:0] req, input logic [2:0] ptr);
    logic [3:0]      res;
    logic [NREQ-1:0] sh;
    int              idx;
    res = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx -= NREQ;
      sh = req >> idx;
      if (sh[0]) res = {1'b1, 3'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    pick       = rr_pick(req_i, ptr_q);
    amp_sh     = amplitude_i >> (int'(pick[2:0]) * WIDTH);
    ang_sh     = angle_i >> (int'(pick[2:0]) * WIDTH);
    ack_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    wdog_d  = wdog_q;
    rec_d   = rec_q;
    ack_d   = '0;
    err_d   = 1'b0;
    cos_d   = cos_q;
    sin_d   = sin_q;
    en_d    = en_q;
    amp_d   = amp_q;
    ang_d   = ang_q;
    nrst_d  = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (pick[3]) begin
          grant_d = pick[2:0];
          amp_d   = amp_sh[WIDTH-1:0];
          ang_d   = ang_sh[WIDTH-1:0];
          en_d    = 1'b1;
          wdog_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (wdog_q == WD_LAST) begin
          en_d    = 1'b0;
          nrst_d  = 1'b0;
          rec_d   = 1'b0;
          state_d = S_RECOVER;
        end else if (state_q == S_ISSUE && !eng_finish_i) begin
          en_d    = 1'b0;
          state_d = S_WAIT;
        end else if (state_q == S_WAIT && eng_finish_i) begin
          cos_d   = eng_cos_i;
          sin_d   = eng_sin_i;
          ack_d   = ack_onehot;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = grant_q;
        state_d = S_IDLE;
      end
      S_RECOVER: begin
        // Engine reset is held for both cycles; the error ack lands in the second one.
        if (!rec_q) begin
          nrst_d = 1'b0;
          rec_d  = 1'b1;
          ack_d  = ack_onehot;
          err_d  = 1'b1;
        end else begin
          rec_d   = 1'b0;
          ptr_d   = grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_RST;
      grant_q <= '0;
      wdog_q  <= '0;
      rec_q   <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      amp_q   <= '0;
      ang_q   <= '0;
      nrst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      wdog_q  <= wdog_d;
      rec_q   <= rec_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      amp_q   <= amp_d;
      ang_q   <= ang_d;
      nrst_q  <= nrst_d;
    end
  end

  assign ack_o           = ack_q;
  assign err_o           = err_q;
  assign cos_o           = cos_q;
  assign sin_o           = sin_q;
  assign grant_o         = grant_q;
  assign busy_o          = busy_q;
  assign eng_enable_o    = en_q;
  assign eng_amplitude_o = amp_q;
  assign eng_angle_o     = ang_q;
  assign eng_nreset_o    = nrst_q;

endmodule

// File: tb/tb_sin_scheduler.sv
// Scoreboard bench for sin_scheduler with a stub engine (cos = angle, sin = amplitude).
module tb_sin_scheduler;
  localparam int WIDTH   = 16;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 63;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] amp;
  logic [NREQ*WIDTH-1:0] ang;
  logic [NREQ-1:0]       ack;
  logic                  err;
  logic [WIDTH-1:0]      cos_v, sin_v;
  logic [2:0]            grant;
  logic                  busy, en, enrst;
  logic [WIDTH-1:0]      eamp, eang;
  logic                  fin = 1'b1;
  logic [WIDTH-1:0]      ecos = '0, esin = '0;

  sin_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .reset_i(rst), .req_i(req), .amplitude_i(amp), .angle_i(ang),
    .ack_o(ack), .err_o(err), .cos_o(cos_v), .sin_o(sin_v), .grant_o(grant),
    .busy_o(busy), .eng_enable_o(en), .eng_amplitude_o(eamp), .eng_angle_o(eang),
    .eng_nreset_o(enrst), .eng_finish_i(fin), .eng_cos_i(ecos), .eng_sin_i(esin)
  );

  always #5 clk = ~clk;

  // Stub engine
  int               L    = 20;
  logic             hang = 1'b0;
  logic             sbusy = 1'b0;
  int               cnt  = 0;
  logic [WIDTH-1:0] l_amp = '0, l_ang = '0;
  always @(posedge clk) begin
    if (!enrst) begin
      fin <= 1'b1; sbusy <= 1'b0; cnt <= 0;
    end else if (en && fin) begin
      fin <= 1'b0; sbusy <= 1'b1; cnt <= L; l_amp <= eamp; l_ang <= eang;
    end else if (sbusy && !hang) begin
      if (cnt <= 1) begin
        fin <= 1'b1; sbusy <= 1'b0; ecos <= l_ang; esin <= l_amp;
      end else cnt <= cnt - 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  typedef struct {
    int               idx;
    logic             err;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] s;
  } exp_t;
  exp_t exp_q[$];
  logic [WIDTH-1:0] last_c = '0, last_s = '0;
  logic mon_on = 1'b0;

  task automatic push_ok(input int idx, input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] s);
    exp_t e;
    e.idx = idx; e.err = 1'b0; e.c = c; e.s = s;
    exp_q.push_back(e);
    last_c = c; last_s = s;
  endtask

  task automatic push_err(input int idx);
    exp_t e;
    e.idx = idx; e.err = 1'b1; e.c = last_c; e.s = last_s;
    exp_q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_on && !rst && ack != '0) begin
      if (exp_q.size() == 0) chk("unexpected_ack", 64'(ack), 64'(0));
      else begin
        e = exp_q.pop_front();
        chk("ack", 64'(ack), 64'(1 << e.idx));
        chk("err", 64'(err), 64'(e.err));
        chk("cos", 64'(cos_v), 64'(e.c));
        chk("sin", 64'(sin_v), 64'(e.s));
        chk("grant", 64'(grant), 64'(e.idx));
      end
    end
  end

  int nlo;
  task automatic wait_acks(input string name, input int n, input int budget, output int first);
    int got, lat;
    got = 0; lat = 0; first = -1; nlo = 0;
    while (got < n && lat < budget) begin
      @(negedge clk);
      lat++;
      if (!enrst) nlo++;
      if (ack != '0) begin
        if (got == 0) first = lat;
        got++;
        req = req & ~ack;
      end
    end
    chk({name, "_ack_count"}, 64'(got), 64'(n));
  endtask

  task automatic finish_txn(input string name);
    @(negedge clk);
    chk({name, "_ack_pulse"}, 64'(ack), 64'(0));
    chk({name, "_busy_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic set_ops(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] g);
    amp[k*WIDTH +: WIDTH] = a;
    ang[k*WIDTH +: WIDTH] = g;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_ack"}, 64'(ack), 64'(0));
    chk({name, "_err"}, 64'(err), 64'(0));
    chk({name, "_busy"}, 64'(busy), 64'(0));
    chk({name, "_en"}, 64'(en), 64'(0));
    chk({name, "_cos"}, 64'(cos_v), 64'(0));
    chk({name, "_sin"}, 64'(sin_v), 64'(0));
    chk({name, "_grant"}, 64'(grant), 64'(0));
    chk({name, "_eamp"}, 64'(eamp), 64'(0));
    chk({name, "_eang"}, 64'(eang), 64'(0));
    chk({name, "_nreset"}, 64'(enrst), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int lat;
    rst = 1'b1; req = '0; amp = '0; ang = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("reset_release_nreset", 64'(enrst), 64'(1));
    mon_on = 1'b1;

    // All three from reset, then again with all held
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NREQ; k++) begin
        set_ops(k, 16'h0100 + 16'(k) + 16'(r * 16'h5000), 16'h0A00 + 16'(k) + 16'(r * 16'h5000));
        push_ok(k, 16'h0A00 + 16'(k) + 16'(r * 16'h5000), 16'h0100 + 16'(k) + 16'(r * 16'h5000));
      end
      req = 3'b111;
      wait_acks("t2", 3, 400, lat);
      finish_txn("t2");
    end

    // Single request, latency 3+L
    set_ops(1, 16'h1000, 16'h2000);
    push_ok(1, 16'h2000, 16'h1000);
    req = 3'b010;
    wait_acks("t1", 1, 100, lat);
    chk("t1_latency", 64'(lat), 64'(3 + L));
    finish_txn("t1");

    // Wrap-around: after 1, requester 2 beats 0
    set_ops(0, 16'h3300, 16'h4400);
    set_ops(2, 16'h3302, 16'h4402);
    push_ok(2, 16'h4402, 16'h3302);
    push_ok(0, 16'h4400, 16'h3300);
    req = 3'b101;
    wait_acks("t3", 2, 200, lat);
    finish_txn("t3");

    // Hung engine: watchdog abort
    hang = 1'b1;
    set_ops(0, 16'h7777, 16'h8888);
    push_err(0);
    req = 3'b001;
    wait_acks("t4", 1, 200, lat);
    chk("t4_latency", 64'(lat), 64'(TIMEOUT + 2));
    chk("t4_nreset_low_cycles", 64'(nlo), 64'(2));
    finish_txn("t4");
    chk("t4_nreset_back", 64'(enrst), 64'(1));
    hang = 1'b0;
    set_ops(0, 16'h1234, 16'h5678);
    push_ok(0, 16'h5678, 16'h1234);
    req = 3'b001;
    wait_acks("t4b", 1, 100, lat);
    chk("t4b_latency", 64'(lat), 64'(3 + L));
    finish_txn("t4b");

    // Operands change and req drops right after grant
    set_ops(2, 16'hAAAA, 16'h5555);
    push_ok(2, 16'h5555, 16'hAAAA);
    req = 3'b100;
    @(negedge clk);
    set_ops(2, 16'h0F0F, 16'hF0F0);
    req = 3'b000;
    chk("t5_grant", 64'(grant), 64'(2));
    @(negedge clk);
    chk("t5_eng_amp", 64'(eamp), 64'(16'hAAAA));
    chk("t5_eng_ang", 64'(eang), 64'(16'h5555));
    wait_acks("t5", 1, 100, lat);
    finish_txn("t5");

    // Reset during WAIT
    set_ops(0, 16'h1111, 16'h2222);
    req = 3'b001;
    repeat (8) @(negedge clk);
    chk("t6_busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    req = 3'b000;
    @(negedge clk);
    check_reset_outputs("t6");
    @(negedge clk);
    rst = 1'b0;
    last_c = '0; last_s = '0;
    @(negedge clk);
    chk("t6_release_nreset", 64'(enrst), 64'(1));
    set_ops(1, 16'h0BAD, 16'hCAFE);
    push_ok(1, 16'hCAFE, 16'h0BAD);
    req = 3'b010;
    wait_acks("t6b", 1, 100, lat);
    chk("t6b_latency", 64'(lat), 64'(3 + L));
    finish_txn("t6b");

    repeat (30) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
